// File: rtl/usb_rx_data_buffer.sv
// Byte FIFO between usb_rx and the AHB-lite slave: usb_rx stores payload bytes,
// the slave drains them one per request, with registered status flags.
module usb_rx_data_buffer #(
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned OCC_W  = ADDR_W + 1
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             store_rx_packet_data,
    input  logic [7:0]       rx_packet_data,
    input  logic             flush,
    input  logic             clear,
    input  logic             get_rx_data,
    output logic [7:0]       rx_data,
    output logic             rx_data_valid,
    output logic [OCC_W-1:0] buffer_occupancy,
    output logic             buffer_empty,
    output logic             buffer_full,
    output logic             overflow,
    output logic             underflow
);

    localparam int unsigned PTR_W = ADDR_W + 1;

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;

    logic             empty_c;
    logic             rd_ok_c;
    logic             wr_ok_c;
    logic [PTR_W-1:0] wptr_nxt;
    logic [PTR_W-1:0] rptr_nxt;
    logic [OCC_W-1:0] occ_nxt;
    logic [7:0]       data_nxt;
    logic             valid_nxt;
    logic             ovf_nxt;
    logic             unf_nxt;

    // Accept decisions; a read while full frees the slot the concurrent write needs.
    always_comb begin
        empty_c   = buffer_empty;
        rd_ok_c   = 1'b0;
        wr_ok_c   = 1'b0;
        wptr_nxt  = wptr;
        rptr_nxt  = rptr;
        data_nxt  = rx_data;
        valid_nxt = 1'b0;
        ovf_nxt   = overflow;
        unf_nxt   = underflow;

        if (flush || clear) begin
            wptr_nxt = '0;
            rptr_nxt = '0;
            ovf_nxt  = 1'b0;
            unf_nxt  = 1'b0;
        end else begin
            rd_ok_c = get_rx_data && !empty_c;
            wr_ok_c = store_rx_packet_data && (!buffer_full || rd_ok_c);

            if (rd_ok_c) begin
                data_nxt  = mem[rptr[ADDR_W-1:0]];
                valid_nxt = 1'b1;
                rptr_nxt  = rptr + PTR_W'(1);
            end else if (get_rx_data) begin
                unf_nxt = 1'b1;
            end

            if (wr_ok_c) begin
                wptr_nxt = wptr + PTR_W'(1);
            end else if (store_rx_packet_data) begin
                ovf_nxt = 1'b1;
            end
        end

        occ_nxt = OCC_W'(wptr_nxt - rptr_nxt);
    end

    // Control and status registers.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            wptr             <= '0;
            rptr             <= '0;
            rx_data          <= 8'h00;
            rx_data_valid    <= 1'b0;
            buffer_occupancy <= '0;
            buffer_empty     <= 1'b1;
            buffer_full      <= 1'b0;
            overflow         <= 1'b0;
            underflow        <= 1'b0;
        end else begin
            wptr             <= wptr_nxt;
            rptr             <= rptr_nxt;
            rx_data          <= data_nxt;
            rx_data_valid    <= valid_nxt;
            buffer_occupancy <= occ_nxt;
            buffer_empty     <= (occ_nxt == '0);
            buffer_full      <= (occ_nxt == OCC_W'(DEPTH));
            overflow         <= ovf_nxt;
            underflow        <= unf_nxt;
        end
    end

    // Storage array is deliberately not reset; the pointers alone define contents.
    always_ff @(posedge clk) begin
        if (n_rst && wr_ok_c) begin
            mem[wptr[ADDR_W-1:0]] <= rx_packet_data;
        end
    end

endmodule

// File: tb/tb_usb_rx_data_buffer.sv
// Bench for usb_rx_data_buffer: directed scenarios plus random traffic,
// all checked each cycle against a queue-based reference model.
module tb_usb_rx_data_buffer;

    localparam int unsigned DEPTH = 64;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       store_rx_packet_data;
    logic [7:0] rx_packet_data;
    logic       flush;
    logic       clear;
    logic       get_rx_data;
    logic [7:0] rx_data;
    logic       rx_data_valid;
    logic [6:0] buffer_occupancy;
    logic       buffer_empty;
    logic       buffer_full;
    logic       overflow;
    logic       underflow;

    int checks = 0;
    int errors = 0;

    // Reference model state
    byte unsigned q[$];
    logic [7:0]   m_data;
    logic         m_valid;
    logic         m_ovf;
    logic         m_unf;

    usb_rx_data_buffer dut (
        .clk                  (clk),
        .n_rst                (n_rst),
        .store_rx_packet_data (store_rx_packet_data),
        .rx_packet_data       (rx_packet_data),
        .flush                (flush),
        .clear                (clear),
        .get_rx_data          (get_rx_data),
        .rx_data              (rx_data),
        .rx_data_valid        (rx_data_valid),
        .buffer_occupancy     (buffer_occupancy),
        .buffer_empty         (buffer_empty),
        .buffer_full          (buffer_full),
        .overflow             (overflow),
        .underflow            (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("rx_data", 32'(rx_data), 32'(m_data));
        chk("rx_data_valid", 32'(rx_data_valid), 32'(m_valid));
        chk("occupancy", 32'(buffer_occupancy), 32'(q.size()));
        chk("empty", 32'(buffer_empty), 32'(q.size() == 0));
        chk("full", 32'(buffer_full), 32'(q.size() == DEPTH));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("underflow", 32'(underflow), 32'(m_unf));
    endtask

    // One clock: drive, let the edge happen, advance the model, compare.
    task automatic cycle(input logic rst, input logic st, input logic [7:0] d,
                         input logic get, input logic fl, input logic cl);
        bit rd_ok;
        bit wr_ok;
        n_rst                = ~rst;
        store_rx_packet_data = st;
        rx_packet_data       = d;
        get_rx_data          = get;
        flush                = fl;
        clear                = cl;
        @(posedge clk);
        #1;
        if (rst) begin
            q.delete();
            m_data = 8'h00; m_valid = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
        end else if (fl || cl) begin
            q.delete();
            m_valid = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
        end else begin
            rd_ok = get && (q.size() > 0);
            wr_ok = st && ((q.size() < DEPTH) || rd_ok);
            m_valid = rd_ok;
            if (rd_ok) m_data = q.pop_front();
            if (get && !rd_ok) m_unf = 1'b1;
            if (st && !wr_ok) m_ovf = 1'b1;
            if (wr_ok) q.push_back(d);
        end
        check_all();
        n_rst = 1'b1; store_rx_packet_data = 1'b0; get_rx_data = 1'b0;
        flush = 1'b0; clear = 1'b0;
    endtask

    initial begin
        n_rst = 1'b0; store_rx_packet_data = 1'b0; rx_packet_data = 8'h00;
        flush = 1'b0; clear = 1'b0; get_rx_data = 1'b0;
        m_data = 8'h00; m_valid = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;

        // 1: reset
        cycle(1, 0, 8'h00, 0, 0, 0);
        cycle(1, 0, 8'h00, 0, 0, 0);
        chk("reset_occ", 32'(buffer_occupancy), 32'd0);
        chk("reset_empty", 32'(buffer_empty), 32'd1);

        // 2: two stores, two gets
        cycle(0, 1, 8'h19, 0, 0, 0);
        chk("t2_occ1", 32'(buffer_occupancy), 32'd1);
        cycle(0, 1, 8'h0F, 0, 0, 0);
        chk("t2_occ2", 32'(buffer_occupancy), 32'd2);
        cycle(0, 0, 8'h00, 1, 0, 0);
        chk("t2_data1", 32'(rx_data), 32'h19);
        chk("t2_valid1", 32'(rx_data_valid), 32'd1);
        cycle(0, 0, 8'h00, 1, 0, 0);
        chk("t2_data2", 32'(rx_data), 32'h0F);
        chk("t2_occ0", 32'(buffer_occupancy), 32'd0);
        cycle(0, 0, 8'h00, 0, 0, 0);
        chk("t2_valid_drop", 32'(rx_data_valid), 32'd0);

        // 3: fill, overflow, drain in order
        for (int i = 0; i < 64; i++) cycle(0, 1, 8'(i), 0, 0, 0);
        chk("t3_full", 32'(buffer_full), 32'd1);
        chk("t3_occ64", 32'(buffer_occupancy), 32'd64);
        cycle(0, 1, 8'hAA, 0, 0, 0);
        chk("t3_overflow", 32'(overflow), 32'd1);
        for (int i = 0; i < 64; i++) begin
            cycle(0, 0, 8'h00, 1, 0, 0);
            chk("t3_drain", 32'(rx_data), 32'(i));
        end
        chk("t3_empty", 32'(buffer_empty), 32'd1);

        // 4: full with simultaneous store/get across the pointer wrap
        for (int i = 0; i < 64; i++) cycle(0, 1, 8'(i), 0, 0, 0);
        cycle(0, 1, 8'h55, 1, 0, 0);
        chk("t4_oldest", 32'(rx_data), 32'h00);
        chk("t4_occ", 32'(buffer_occupancy), 32'd64);
        for (int i = 0; i < 64; i++) cycle(0, 0, 8'h00, 1, 0, 0);
        chk("t4_last", 32'(rx_data), 32'h55);

        // 5: get while empty together with a store
        cycle(0, 1, 8'h3C, 1, 0, 0);
        chk("t5_valid", 32'(rx_data_valid), 32'd0);
        chk("t5_underflow", 32'(underflow), 32'd1);
        chk("t5_occ", 32'(buffer_occupancy), 32'd1);

        // 6: flush then clear at occupancy 10, each with a store in flight
        for (int i = 0; i < 9; i++) cycle(0, 1, 8'(8'h80 + i), 0, 0, 0);
        chk("t6_occ10", 32'(buffer_occupancy), 32'd10);
        cycle(0, 1, 8'hEE, 0, 1, 0);
        chk("t6_flush_occ", 32'(buffer_occupancy), 32'd0);
        chk("t6_flush_flags", 32'({overflow, underflow}), 32'd0);
        for (int i = 0; i < 10; i++) cycle(0, 1, 8'(8'hC0 + i), 0, 0, 0);
        cycle(0, 1, 8'hEE, 0, 0, 1);
        chk("t6_clear_occ", 32'(buffer_occupancy), 32'd0);
        chk("t6_clear_empty", 32'(buffer_empty), 32'd1);

        // Random traffic with phases biased toward filling and draining
        for (int i = 0; i < 3000; i++) begin
            int unsigned ps;
            int unsigned pg;
            ps = ((i / 200) % 2 == 0) ? 75 : 30;
            pg = 100 - ps;
            cycle($urandom_range(999) < 3,
                  $urandom_range(99) < ps,
                  8'($urandom),
                  $urandom_range(99) < pg,
                  $urandom_range(999) < 8,
                  $urandom_range(999) < 8);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
